// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int unsigned IR_COUNT    = 8;
    localparam logic [2:0]  SPURIOUS_IR = 3'd7;
    localparam int unsigned VEC_BASE_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        ACK1,
        GAP,
        ACK2
    } state_t;

    function automatic logic [IR_COUNT-1:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/pic_prio_find.sv
// Finds the highest-priority set bit of an 8-bit vector, scanning upward
// from base with wrap-around.
module pic_prio_find
    import pic_pkg::*;
(
    input  logic [IR_COUNT-1:0] vec,
    input  logic [2:0]          base,
    output logic [2:0]          index,
    output logic                found
);

    logic [2:0] cand;

    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < IR_COUNT; i++) begin
            cand = base + 3'(i);
            if (!found && vec[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// INTA handshake sequencer: raises INT, walks the two-pulse acknowledge,
// drives the vector byte and generates ISR/IRR strobes and EOI clears.
// Optional feature macro: AUTO_ROTATE_EN (priority rotation on clear).
module inta_sequencer
    import pic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  int_req,
    input  logic [2:0]            req_index,
    input  logic                  inta_n,
    input  logic [VEC_BASE_W-1:0] icw2_base,
    input  logic                  aeoi,
    input  logic                  eoi_cmd,
    input  logic                  eoi_specific,
    input  logic [2:0]            eoi_level,
    input  logic                  rotate,
    input  logic [IR_COUNT-1:0]   isr,
    output logic                  int_out,
    output logic                  freeze,
    output logic                  isr_set,
    output logic                  irr_clr,
    output logic [2:0]            ack_index,
    output logic [IR_COUNT-1:0]   isr_clr,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    output logic [2:0]            priority_base
);

    state_t              state;
    state_t              next_state;
    logic                inta_d;
    logic                inta_fall;
    logic                inta_rise;
    logic [2:0]          ack_q;
    logic                spurious_q;
    logic                isr_set_q;
    logic [IR_COUNT-1:0] isr_clr_q;
    logic                aeoi_clear;
    logic [IR_COUNT-1:0] eoi_mask;
    logic [IR_COUNT-1:0] clr_next;
    logic [2:0]          scan_base;
    logic [2:0]          found_idx;
    logic                found;

    assign inta_fall = inta_d & ~inta_n;
    assign inta_rise = ~inta_d & inta_n;

    pic_prio_find u_prio_find (
        .vec   (isr),
        .base  (scan_base),
        .index (found_idx),
        .found (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inta_d     <= 1'b1;
            ack_q      <= '0;
            spurious_q <= 1'b0;
            isr_set_q  <= 1'b0;
            isr_clr_q  <= '0;
        end else begin
            state     <= next_state;
            inta_d    <= inta_n;
            isr_set_q <= (state == PEND) && inta_fall && int_req;
            isr_clr_q <= clr_next;
            if ((state == IDLE) && int_req) begin
                ack_q      <= req_index;
                spurious_q <= 1'b0;
            end else if ((state == PEND) && inta_fall && !int_req) begin
                ack_q      <= SPURIOUS_IR;
                spurious_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        int_out    = 1'b0;
        freeze     = 1'b0;
        data_oe    = 1'b0;
        aeoi_clear = 1'b0;
        unique case (state)
            IDLE: begin
                if (int_req) next_state = PEND;
            end
            PEND: begin
                int_out = 1'b1;
                if (inta_fall) next_state = ACK1;
            end
            ACK1: begin
                freeze = 1'b1;
                if (inta_rise) next_state = GAP;
            end
            GAP: begin
                freeze = 1'b1;
                if (inta_fall) next_state = ACK2;
            end
            ACK2: begin
                freeze  = 1'b1;
                data_oe = !inta_n;
                if (inta_rise) begin
                    next_state = IDLE;
                    aeoi_clear = aeoi && !spurious_q;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // EOI runs beside the FSM; a coinciding AEOI clear is merged into the same mask.
    always_comb begin
        eoi_mask = '0;
        if (eoi_cmd) begin
            if (eoi_specific) eoi_mask = onehot8(eoi_level);
            else if (found)   eoi_mask = onehot8(found_idx);
        end
        clr_next = eoi_mask | (aeoi_clear ? onehot8(ack_q) : '0);
    end

`ifdef AUTO_ROTATE_EN
    logic [2:0] prio_q;
    logic [2:0] prio_next;
    logic [2:0] eoi_idx;

    always_comb begin
        eoi_idx   = eoi_specific ? eoi_level : found_idx;
        prio_next = prio_q;
        if (aeoi_clear) prio_next = 3'(ack_q + 3'd1);
        if (eoi_cmd && rotate && (eoi_mask != '0)) prio_next = 3'(eoi_idx + 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= '0;
        else     prio_q <= prio_next;
    end

    assign scan_base     = prio_q;
    assign priority_base = prio_q;
`else
    logic unused_rotate;

    assign unused_rotate = rotate;
    assign scan_base     = '0;
    assign priority_base = '0;
`endif

    assign isr_set   = isr_set_q;
    assign irr_clr   = isr_set_q;
    assign ack_index = ack_q;
    assign isr_clr   = isr_clr_q;
    assign data_out  = data_oe ? {icw2_base, ack_q} : '0;

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port int_req, input, 1 bit: resolver reports a pending request that outranks the ISR (level).
REQ-004 SHALL have port req_index, input, 3 bits: IR number of that request.
REQ-005 SHALL have port inta_n, input, 1 bit: CPU acknowledge, active-low, already synchronous to clk.
REQ-006 SHALL have port icw2_base, input, 5 bits: vector base T7..T3.
REQ-007 SHALL have port aeoi, input, 1 bit: auto-EOI mode.
REQ-008 SHALL have port eoi_cmd, input, 1 bit: one-cycle OCW2 EOI strobe.
REQ-009 SHALL have port eoi_specific, input, 1 bit: OCW2 SL bit.
REQ-010 SHALL have port eoi_level, input, 3 bits: OCW2 L2..L0.
REQ-011 SHALL have port rotate, input, 1 bit: OCW2 R bit.
REQ-012 SHALL have port isr, input, 8 bits: current ISR contents.
REQ-013 SHALL have port int_out, output, 1 bit: INT pin to CPU.
REQ-014 SHALL have port freeze, output, 1 bit: holds resolver inputs during acknowledge.
REQ-015 SHALL have port isr_set, output, 1 bit: one-cycle strobe that sets ISR[ack_index].
REQ-016 SHALL have port irr_clr, output, 1 bit: one-cycle strobe that clears IRR[ack_index].
REQ-017 SHALL have port ack_index, output, 3 bits: latched IR being acknowledged.
REQ-018 SHALL have port isr_clr, output, 8 bits: one-cycle one-hot ISR clear mask.
REQ-019 SHALL have port data_out, output, 8 bits: vector byte.
REQ-020 SHALL have port data_oe, output, 1 bit: data bus drive enable.
REQ-021 SHALL have port priority_base, output, 3 bits: IR number currently holding the highest priority.

Function
REQ-022 States SHALL be IDLE, PEND, ACK1, GAP, ACK2; inta_n falling and rising edges are detected from a one-cycle delayed copy of inta_n.
REQ-023 In IDLE with int_req=1, next state SHALL be PEND; req_index latched into ack_index; int_out=1 from the following cycle.
REQ-024 In PEND, an inta_n falling edge SHALL move the FSM to ACK1; int_out=0, freeze=1 and isr_set=irr_clr=1 for exactly that cycle.
REQ-025 If int_req=0 at the PEND->ACK1 edge (spurious request), ack_index SHALL become 7, and isr_set and irr_clr SHALL stay 0.
REQ-026 ACK1 SHALL move to GAP on an inta_n rising edge; GAP SHALL move to ACK2 on the next falling edge; data_oe=0 throughout ACK1 and GAP.
REQ-027 In ACK2, data_out SHALL be {icw2_base, ack_index} and data_oe=1 while inta_n=0.
REQ-028 An inta_n rising edge in ACK2 SHALL return the FSM to IDLE with freeze=0 and data_oe=0; if aeoi=1 and the request was not spurious, isr_clr SHALL be one-hot(ack_index) in that cycle.
REQ-029 A non-specific EOI (eoi_cmd=1, eoi_specific=0) SHALL clear the highest-priority set isr bit, scanning from priority_base upward modulo 8; with isr=0 the mask SHALL be 0.
REQ-030 A specific EOI SHALL assert isr_clr = one-hot(eoi_level) whether or not that bit is set.
REQ-031 An EOI coinciding with an AEOI clear SHALL produce the OR of both masks in the same cycle.
REQ-032 EOI SHALL be processed in any FSM state without disturbing the FSM.
REQ-033 inta_n edges in IDLE SHALL be ignored.

Reset
REQ-034 rst=1 SHALL force IDLE, with int_out, freeze, isr_set, irr_clr and data_oe at 0, isr_clr=0, ack_index=0, data_out=0, priority_base=0 on the next edge, including mid-acknowledge.

Configuration
REQ-035 With AUTO_ROTATE_EN defined, an EOI with rotate=1, or an AEOI clear, that clears bit n SHALL set priority_base to (n+1) mod 8 in the same cycle as the clear; 3-bit wrap.
REQ-036 Without AUTO_ROTATE_EN, priority_base SHALL stay 0, the rotate port SHALL exist but be ignored, and the scan order SHALL be fixed at IR0 highest.

Structure
REQ-037 Package pic_pkg SHALL hold the state enum, IR_COUNT=8, SPURIOUS_IR=7 and the vector-base width.
REQ-038 Sub-module pic_prio_find SHALL return the index and found flag of the highest-priority set bit of an 8-bit vector, given a base.

Verification
REQ-039 Bench SHALL cover: icw2_base=5'b01000, int_req with req_index=3, two INTA pulses -> isr_set/irr_clr for one cycle at the first fall, data_out=8'h43 with data_oe=1 during the second pulse.
REQ-040 Bench SHALL cover: int_req dropped before the first INTA -> ack_index=7, no isr_set, second pulse drives 8'h47.
REQ-041 Bench SHALL cover: aeoi=1, IR5 acknowledge -> isr_clr=8'h20 on the second rising edge; with AUTO_ROTATE_EN, priority_base=6.
REQ-042 Bench SHALL cover: isr=8'h84 with priority_base=3, non-specific EOI -> isr_clr=8'h80, then with AUTO_ROTATE_EN rotate=1 -> priority_base=0.
REQ-043 Bench SHALL cover: specific EOI with level 2 in the same cycle as an AEOI clear of IR1 -> isr_clr=8'h06.
REQ-044 Bench SHALL cover: rst asserted in GAP -> next cycle IDLE with all outputs 0; later inta_n pulses are ignored.
